dense_param_loader: RTL and testbench
=====================================

# dense_param_loader

Streaming parameter writer for the dense `layer` block: it accepts a word stream over a valid/ready handshake and writes it into the layer's flat weight memory and bias memory. This replaces `$readmemh` preloading, so weights can be loaded at run time from a host or DMA front end. The block sits between the parameter source and the layer's memory write ports, and signals completion so inference can start.

## Interface
- `NEURONS`, default 4: neurons in the target layer (bias memory depth).
- `INPUTS`, default 10: inputs per neuron.
- `N_WEIGHTS`, default `NEURONS*INPUTS` (40): weight memory depth.
- `DATA_W`, default 32: parameter word width.

Ports:
- `CLK` in 1: clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: begin a load sequence; sampled only in IDLE or DONE.
- `s_data` in DATA_W: parameter word.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader can accept a word.
- `w_we` out 1: weight memory write enable.
- `w_addr` out $clog2(N_WEIGHTS): weight write address.
- `b_we` out 1: bias memory write enable.
- `b_addr` out $clog2(NEURONS): bias write address.
- `wr_data` out DATA_W: write data, shared by both memories.
- `busy` out 1: a load sequence is in progress.
- `done` out 1: load complete; held until the next `start` or reset.
- `err` out 1: checksum mismatch. Only active when the checksum feature is compiled in; otherwise tied to 0.

## Operation
- States: IDLE, LOAD_W, LOAD_B, CHECK (only when checksum is compiled in), DONE.
- IDLE/DONE, when `start`=1: go to LOAD_W. Clear the counters and `done`, and also `err` and the accumulator.
- LOAD_W:
  - `s_ready`=1.
  - Each beat (`s_valid && s_ready`) writes weight index k = neuron*INPUTS + input, with k running 0..N_WEIGHTS-1. This matches the layer's flat weight order.
  - After beat k=N_WEIGHTS-1, go to LOAD_B.
- LOAD_B:
  - `s_ready`=1.
  - Beats write bias index 0..NEURONS-1.
  - After the last bias beat, go to CHECK if it is compiled in, otherwise DONE.
- CHECK: `s_ready`=1. Accept one word, compare it, then go to DONE.
- DONE: `done`=1, `s_ready`=0.
- `s_valid` low stalls the sequence with no side effects. `s_data` is don't-care when `s_valid`=0.
- `start` is ignored while `busy`.
- Data is passed through unmodified; there is no arithmetic on parameter values.
- Reset mid-load returns to IDLE and clears all outputs. Words already written stay in the memories. No writes are issued after reset is asserted.

## Timing
- Reset values: `s_ready`=0, `w_we`=0, `b_we`=0, `w_addr`=0, `b_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0.
- Write latency is 1 cycle. A beat accepted at edge n produces `w_we`/`b_we`=1 with the address and data valid during cycle n+1, for exactly one cycle.
- `s_ready` is a registered state decode. It drops the cycle after the last accepted beat of the sequence.
- `busy` rises the cycle after `start` is sampled. It falls in the same cycle that `done` rises.
- `done` rises the cycle after the final write pulse (or after the checksum compare). So `done` is never high while a write is pending.
- With no stalls and the checksum compiled out, a full load takes N_WEIGHTS+NEURONS beats on consecutive cycles. `done` asserts 2 cycles after the last beat edge.
- Boundary cases:
  - At the LOAD_W to LOAD_B transition, `w_addr` for the last weight and `b_addr`=0 on the next beat appear on consecutive cycles with no bubble.
  - `start` in the same cycle as a reset release is ignored.

## Configuration
- `DENSE_LOADER_CHECKSUM_EN` defined:
  - A DATA_W-bit XOR accumulator covers all weight and bias words.
  - The CHECK state consumes one extra word.
  - `err` is set in DONE if that word differs from the accumulator. The memories are still written.
- Macro undefined: no CHECK state, no accumulator, `err` is constant 0, and the stream is N_WEIGHTS+NEURONS words.

## Structure
- Shared package `dense_pkg`:
  - the state enum `loader_state_t`;
  - the default `DATA_W`;
  - a helper function `w_index(neuron, input)` that the layer also uses for its flat weight addressing.
- No sub-module is needed. The checksum accumulator stays inline under the macro.

## Test plan
- Default params, 44 words 0x00000000..0x0000002B streamed without stalls: `w_we` pulses 40 times with `w_addr` 0..39 and `wr_data` = addr. `b_we` then pulses 4 times with `b_addr` 0..3 and data 0x28..0x2B. `done`=1 two cycles after the last beat.
- Same stream with `s_valid` toggling every other cycle: identical memory contents, 44 write pulses, no duplicate addresses.
- `reset` pulled low after 20 beats: all outputs go to 0 immediately. A new `start` followed by 44 words completes normally.
- `start` pulsed during LOAD_W at beat 5: ignored, and the sequence is unchanged.
- Checksum compiled in: after 44 words, sending the XOR of all words leaves `err`=0. Sending that XOR with bit 0 flipped gives `err`=1, `done`=1, and all 44 writes still performed.
- `start` while in DONE: `done` clears the next cycle and `busy`=1. A second load overwrites address 0 with the new first word.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense layer and its parameter loader.
// Holds the loader state encoding, default word width and flat weight index.
package dense_pkg;

    localparam int DENSE_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_B,
        ST_CHECK,
        ST_DONE
    } loader_state_t;

    // Flat weight address: all inputs of neuron 0 first, then neuron 1, ...
    function automatic int w_index(
        input int neuron,
        input int in_idx,
        input int n_inputs
    );
        return neuron * n_inputs + in_idx;
    endfunction

endpackage

// File: rtl/dense_param_loader_if.sv
// Valid/ready parameter word stream into the dense parameter loader.
// Ports: s_data/s_valid from the source, s_ready back from the loader.
interface dense_param_loader_if
    import dense_pkg::*;
#(
    parameter int DATA_W = DENSE_DATA_W
);

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/dense_param_loader.sv
// Streams weight then bias words into the dense layer's memories.
// Ports: CLK, reset (async, active-low), start, s (stream slave),
//   w_we/w_addr, b_we/b_addr, wr_data (shared), busy, done, err.
// Optional macro DENSE_LOADER_CHECKSUM_EN adds an XOR checksum word.
module dense_param_loader
    import dense_pkg::*;
#(
    parameter int NEURONS   = 4,
    parameter int INPUTS    = 10,
    parameter int N_WEIGHTS = NEURONS * INPUTS,
    parameter int DATA_W    = DENSE_DATA_W,
    localparam int AW = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1,
    localparam int BW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    dense_param_loader_if.slave s,
    output logic              w_we,
    output logic [AW-1:0]     w_addr,
    output logic              b_we,
    output logic [BW-1:0]     b_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              w_we_q, w_we_d;
    logic              b_we_q, b_we_d;
    logic [AW-1:0]     w_addr_q, w_addr_d;
    logic [BW-1:0]     b_addr_q, b_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              s_ready_q, s_ready_d;
    // Low until the first edge after reset release, so a start
    // coinciding with the release is not taken.
    logic              armed_q;
    logic              beat;
    logic              go;
`ifdef DENSE_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              err_q, err_d;
`endif

    assign beat = s.s_valid && s_ready_q;
    assign go   = start && armed_q && !busy_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_we_d    = 1'b0;
        b_we_d    = 1'b0;
        w_addr_d  = w_addr_q;
        b_addr_d  = b_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef DENSE_LOADER_CHECKSUM_EN
        acc_d     = acc_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // done/busy trail the state by one cycle so done
                // only rises once the final write pulse is over.
                if (state_q == ST_DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                if (go) begin
                    state_d = ST_LOAD_W;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef DENSE_LOADER_CHECKSUM_EN
                    acc_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD_W: begin
                if (beat) begin
                    w_we_d    = 1'b1;
                    w_addr_d  = idx_q;
                    wr_data_d = s.s_data;
`ifdef DENSE_LOADER_CHECKSUM_EN
                    acc_d     = acc_q ^ s.s_data;
`endif
                    if (idx_q == AW'(N_WEIGHTS - 1)) begin
                        state_d = ST_LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = AW'(idx_q + 1'b1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (beat) begin
                    b_we_d    = 1'b1;
                    b_addr_d  = BW'(idx_q);
                    wr_data_d = s.s_data;
`ifdef DENSE_LOADER_CHECKSUM_EN
                    acc_d     = acc_q ^ s.s_data;
`endif
                    if (idx_q == AW'(NEURONS - 1)) begin
`ifdef DENSE_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                        idx_d   = '0;
                    end else begin
                        idx_d = AW'(idx_q + 1'b1);
                    end
                end
            end
`ifdef DENSE_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (beat) begin
                    err_d   = (s.s_data != acc_q);
                    state_d = ST_DONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d == ST_LOAD_W) ||
                    (state_d == ST_LOAD_B) ||
                    (state_d == ST_CHECK);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            w_we_q    <= 1'b0;
            b_we_q    <= 1'b0;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            armed_q   <= 1'b0;
`ifdef DENSE_LOADER_CHECKSUM_EN
            acc_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            w_we_q    <= w_we_d;
            b_we_q    <= b_we_d;
            w_addr_q  <= w_addr_d;
            b_addr_q  <= b_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
            armed_q   <= 1'b1;
`ifdef DENSE_LOADER_CHECKSUM_EN
            acc_q     <= acc_d;
            err_q     <= err_d;
`endif
        end
    end

    assign s.s_ready = s_ready_q;
    assign w_we      = w_we_q;
    assign b_we      = b_we_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef DENSE_LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_dense_param_loader.sv
// Scoreboard bench for dense_param_loader: expected writes are queued
// by the driver and popped by a negedge monitor on each write pulse.
module tb_dense_param_loader;
    import dense_pkg::*;

    localparam int NEU = 4;
    localparam int INP = 10;
    localparam int NW  = NEU * INP;
    localparam int NB  = NEU;
    localparam int TOT = NW + NB;

    typedef struct packed {
        logic        bias;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        w_we;
    logic [5:0]  w_addr;
    logic        b_we;
    logic [1:0]  b_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    wr_t exp_q[$];

    dense_param_loader_if #(.DATA_W(32)) sif ();

    dense_param_loader #(
        .NEURONS(NEU),
        .INPUTS (INP)
    ) dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .s      (sif),
        .w_we   (w_we),
        .w_addr (w_addr),
        .b_we   (b_we),
        .b_addr (b_addr),
        .wr_data(wr_data),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued write.
    always @(negedge CLK) begin
        wr_t e;
        wr_t g;
        if (w_we || b_we) begin
            checks++;
            g.bias = b_we;
            g.addr = b_we ? {4'b0, b_addr} : w_addr;
            g.data = wr_data;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h expected none", g);
            end else begin
                e = exp_q.pop_front();
                if ((w_we && b_we) || g !== e) begin
                    errors++;
                    $display("FAIL write: got %h expected %h", g, e);
                end
            end
            chk("done_during_write", {31'b0, done}, 32'h0);
        end
    end

    // Drive one word at a negedge; returns at the negedge after acceptance.
    task automatic beat(input logic [31:0] d, input int k);
        int w;
        wr_t e;
        sif.s_data  = d;
        sif.s_valid = 1'b1;
        w = 0;
        while (!sif.s_ready && w < 20) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1");
            sif.s_valid = 1'b0;
            return;
        end
        if (k >= 0) begin
            e.data = d;
            if (k < NW) begin
                e.bias = 1'b0;
                e.addr = 6'(w_index(k / INP, k % INP, INP));
            end else begin
                e.bias = 1'b1;
                e.addr = 6'(k - NW);
            end
            exp_q.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("start_busy", {31'b0, busy}, 32'h1);
        chk("start_ready", {31'b0, sif.s_ready}, 32'h1);
        chk("start_done", {31'b0, done}, 32'h0);
        chk("start_err", {31'b0, err}, 32'h0);
    endtask

    task automatic load(input logic [31:0] base, input bit stall,
                        input int start_at, input bit bad_sum);
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < TOT; k++) begin
            if (k == start_at) start = 1'b1;
            beat(base + 32'(k), k);
            start = 1'b0;
            x = x ^ (base + 32'(k));
            if (stall && k != TOT - 1) begin
                sif.s_valid = 1'b0;
                sif.s_data  = 32'hDEAD0000 | 32'(k);
                @(negedge CLK);
            end
        end
`ifdef DENSE_LOADER_CHECKSUM_EN
        beat(bad_sum ? (x ^ 32'h1) : x, -1);
`endif
        sif.s_valid = 1'b0;
        chk("ready_drop", {31'b0, sif.s_ready}, 32'h0);
        chk("done_early", {31'b0, done}, 32'h0);
        chk("busy_before_done", {31'b0, busy}, 32'h1);
        @(negedge CLK);
        chk("done_rise", {31'b0, done}, 32'h1);
        chk("busy_fall", {31'b0, busy}, 32'h0);
        chk("err", {31'b0, err}, {31'b0, bad_sum});
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_w_we"}, {31'b0, w_we}, 32'h0);
        chk({tag, "_b_we"}, {31'b0, b_we}, 32'h0);
        chk({tag, "_w_addr"}, {26'b0, w_addr}, 32'h0);
        chk({tag, "_b_addr"}, {30'b0, b_addr}, 32'h0);
        chk({tag, "_wr_data"}, wr_data, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_done"}, {31'b0, done}, 32'h0);
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
        chk({tag, "_s_ready"}, {31'b0, sif.s_ready}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        repeat (2) @(negedge CLK);
        chk_zero("reset");

        // start coinciding with reset release must be ignored
        reset = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("rel_start_busy", {31'b0, busy}, 32'h0);
        chk("rel_start_ready", {31'b0, sif.s_ready}, 32'h0);
        @(negedge CLK);

        // straight load, no stalls
        do_start();
        load(32'h0, 1'b0, -1, 1'b0);

        // restart from DONE, stalled stream
        do_start();
        load(32'h0, 1'b1, -1, 1'b0);

        // restart with new data, start pulse mid-load ignored
        do_start();
        load(32'h100, 1'b0, 5, 1'b0);

        // reset after 20 beats
        do_start();
        for (int k = 0; k < 20; k++) beat(32'h300 + 32'(k), k);
        sif.s_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        chk("midrst_queue", 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        do_start();
        load(32'h200, 1'b0, -1, 1'b0);

`ifdef DENSE_LOADER_CHECKSUM_EN
        do_start();
        load(32'h0, 1'b0, -1, 1'b0);
        do_start();
        load(32'h0, 1'b0, -1, 1'b1);
`endif

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
